// File: rtl/feature_counter_pkg.sv
// rtl/feature_counter_pkg.sv - shared defaults and popcount helper for feature_counter
package feature_counter_pkg;

    localparam int DEFAULT_INPUT_FEATURES  = 8;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int POPCOUNT_MAX_WIDTH      = 256;

    // Callers zero-extend their vector to POPCOUNT_MAX_WIDTH bits.
    function automatic int unsigned popcount(input logic [POPCOUNT_MAX_WIDTH-1:0] vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POPCOUNT_MAX_WIDTH; i++) begin
            n = n + 32'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/feature_debouncer.sv
// rtl/feature_debouncer.sv - two-flop synchronizer plus optional stable-window debounce
module feature_debouncer
    import feature_counter_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_INPUT_FEATURES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit DEBOUNCE_EN     = 1'b1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] features_i,
    output logic [WIDTH-1:0] accepted_o,
    output logic             accept_o
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= features_i;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE_EN) begin : g_debounce
            localparam int SW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [SW-1:0] STABLE_MAX  = SW'(DEBOUNCE_CYCLES);
            localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE_CYCLES - 1);

            logic [WIDTH-1:0] candidate;
            logic [SW-1:0]    stable_cnt;

            // Saturating at STABLE_MAX keeps a held vector from being accepted twice.
            always_ff @(posedge clock_i or negedge reset_i) begin
                if (!reset_i) begin
                    candidate  <= '0;
                    stable_cnt <= '0;
                end else if (sync2 != candidate) begin
                    candidate  <= sync2;
                    stable_cnt <= '0;
                end else if (stable_cnt != STABLE_MAX) begin
                    stable_cnt <= stable_cnt + SW'(1);
                end
            end

            assign accepted_o = candidate;
            assign accept_o   = (stable_cnt == STABLE_LAST) && (sync2 == candidate);
        end else begin : g_passthru
            assign accepted_o = sync2;
            assign accept_o   = 1'b1;
        end
    endgenerate

endmodule

// File: rtl/feature_counter.sv
// rtl/feature_counter.sv - counts accepted active feature lines; debounce selected by FEATURE_COUNTER_DEBOUNCE_EN
module feature_counter
    import feature_counter_pkg::*;
#(
    parameter int INPUT_FEATURES  = DEFAULT_INPUT_FEATURES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                                clock_i,
    input  logic                                reset_i,
    input  logic [INPUT_FEATURES-1:0]           features_i,
    output logic [$clog2(INPUT_FEATURES+1)-1:0] counter_o,
    output logic                                changed_o
);

    localparam int CW = $clog2(INPUT_FEATURES + 1);

`ifdef FEATURE_COUNTER_DEBOUNCE_EN
    localparam bit DEBOUNCE_EN = 1'b1;
`else
    localparam bit DEBOUNCE_EN = 1'b0;
`endif

    logic [INPUT_FEATURES-1:0] accepted;
    logic                      accept;
    logic [CW-1:0]             count_next;

    feature_debouncer #(
        .WIDTH           (INPUT_FEATURES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEBOUNCE_EN     (DEBOUNCE_EN)
    ) u_debouncer (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .features_i (features_i),
        .accepted_o (accepted),
        .accept_o   (accept)
    );

    assign count_next = CW'(popcount(POPCOUNT_MAX_WIDTH'(accepted)));

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            counter_o <= '0;
            changed_o <= 1'b0;
        end else begin
            changed_o <= accept && (count_next != counter_o);
            if (accept) begin
                counter_o <= count_next;
            end
        end
    end

endmodule
